// File: rtl/bin_to_bcd_converter_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding, BCD
// register geometry and the digit code shown when a value is out of range.
package bin_to_bcd_converter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Five nibbles cover the full 16-bit range (up to 65535); only four are shown.
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // Non-decimal code the display driver renders as its default pattern.
  localparam logic [3:0] OVF_DIGIT = 4'hF;

endpackage

// File: rtl/bin_to_bcd_converter_add3_adjust.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_adjust (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Pure combinational ">=5 then +3" correction.
  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter feeding the seven-segment
// driver. One shift per clock; digits and ovf are registered and only update
// when a conversion completes, so the display never sees partial values.
module bin_to_bcd_converter
  import bin_to_bcd_converter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       units,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     bin_sh;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     bcd_adj;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_pend;

  // Zero-extend both sides to 32 bits so narrow WIDTH values compare without
  // truncation; for WIDTH < 14 the result is constant 0 and folds away.
  function automatic logic exceeds_max(input logic [WIDTH-1:0] v);
    return 32'(v) > 32'(MAX_VAL);
  endfunction

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_add3_adjust u_adj (
      .d (bcd[4*g +: 4]),
      .q (bcd_adj[4*g +: 4])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: IDLE waits for start, CONV runs WIDTH shifts, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion datapath: load on accept, then adjust-and-shift {bcd, bin_sh}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_sh   <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_sh   <= value;
            bcd      <= '0;
            cnt      <= '0;
            ovf_pend <= exceeds_max(value);
          end
        end
        CONV: begin
          // The adjusted fifth nibble never reaches 8, so dropping its MSB is lossless.
          bcd    <= BCD_W'({bcd_adj, bin_sh[WIDTH-1]});
          bin_sh <= bin_sh << 1;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered handshake and result outputs; results change only when leaving DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      units     <= '0;
      tens      <= '0;
      hundreds  <= '0;
      thousands <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state == DONE);
      if (state == DONE) begin
        ovf <= ovf_pend;
        if (ovf_pend) begin
          units     <= OVF_DIGIT;
          tens      <= OVF_DIGIT;
          hundreds  <= OVF_DIGIT;
          thousands <= OVF_DIGIT;
        end else begin
          units     <= bcd[3:0];
          tens      <= bcd[7:4];
          hundreds  <= bcd[11:8];
          thousands <= bcd[15:12];
        end
      end
    end
  end

endmodule

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
- Sequential double-dabble converter that turns a binary result word from the CPU into four BCD digits (units, tens, hundreds, thousands).
- Sits directly upstream of the seven-segment display driver and feeds its four 4-bit digit inputs.
- Uses a start/busy/done handshake, one bit per clock.
- Digit outputs are registered and hold the last completed result, so the display never shows partial values.

Parameters:
- WIDTH, 16, width of binary input; legal range 4..16.
- MAX_VAL, 9999, largest value shown as digits; anything above is flagged as overflow.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- value  input  WIDTH  binary number to convert; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digits are valid.
- ovf  output  1  registered; high when the last completed conversion had value > MAX_VAL.
- units  output  4  BCD digit 0.
- tens  output  4  BCD digit 1.
- hundreds  output  4  BCD digit 2.
- thousands  output  4  BCD digit 3.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, ovf=0, all digits=0, internal shift/BCD/counter registers=0.
- State machine has three states: IDLE, CONV, DONE.
- IDLE:
  - On an edge with start=1: load bin_sh=value, bcd=0 (20 bits, 5 nibbles), cnt=0, ovf_pend=(value>MAX_VAL); go to CONV.
  - Otherwise stay in IDLE.
- CONV, every edge:
  - Each bcd nibble >=5 gets +3 (all nibbles adjusted in parallel, combinationally).
  - Then {bcd,bin_sh} shifts left by 1.
  - cnt increments.
  - When cnt==WIDTH-1 on this edge, go to DONE.
  - Exactly WIDTH shift cycles are performed.
- DONE, one cycle, on entry edge:
  - Digits register from bcd[15:0] (units=bcd[3:0] … thousands=bcd[15:12]); ovf=ovf_pend.
  - If ovf_pend=1, all four digits=4'hF instead. The display shows its default pattern for non-decimal codes.
  - done=1 for exactly this cycle; next edge returns to IDLE.
- busy=1 in CONV and DONE; busy=0 in IDLE. busy and done are registered, no combinational path from start.
- Latency: start sampled on edge N -> done high in cycle after edge N+WIDTH+1 (17 edges for WIDTH=16). Throughput is one conversion per WIDTH+2 cycles.
- start while busy=1 is ignored: no queueing, no reload, value changes have no effect.
- start held high continuously: a new conversion is accepted on the first IDLE edge, i.e. back-to-back with a one-cycle IDLE gap.
- Digit outputs and ovf change only on DONE entry; they hold between conversions.
- Reset mid-conversion: immediate return to IDLE with all outputs cleared; no done pulse.
- value=0 -> digits 0,0,0,0, ovf=0. value=MAX_VAL -> 9,9,9,9, ovf=0. value=MAX_VAL+1 -> F,F,F,F, ovf=1.
- Fifth BCD nibble exists only for WIDTH=16 range; it is never output.
- For WIDTH<14, overflow cannot occur, and the compare must tie off cleanly (no width-truncation warnings).

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, CONV=2'd1, DONE=2'd2;
  - BCD_DIGITS=5;
  - OVF_DIGIT=4'hF.
- One natural sub-module: bcd_add3_adjust, a combinational per-nibble ">=5 then +3" cell, instantiated BCD_DIGITS times.
- FSM, counter and output registers stay in the top module.

Test Plan:
- Reset then idle: rst low 3 cycles, release -> busy=0, done=0, ovf=0, digits 0/0/0/0 until a start.
- value=16'd1234, start 1 cycle:
  - busy rises next cycle;
  - done pulses exactly 17 edges after the sampling edge;
  - thousands=1, hundreds=2, tens=3, units=4, ovf=0.
- Boundaries:
  - value=0 -> 0000, ovf=0.
  - value=9999 -> 9999, ovf=0.
  - value=10000 -> FFFF, ovf=1.
  - A following value=7 conversion -> 0007 with ovf cleared.
- Start while busy: start 1234, pulse start with value=5678 at cycle 5 -> result 1234, single done pulse; 5678 never appears.
- Reset mid-conversion: assert rst at cycle 8 of a 4321 conversion -> outputs 0 immediately, no done pulse; a fresh start of 42 -> 0042.
- Continuous start=1 with value stepping 0..20 -> each done reports the value sampled at its accepting edge; done spacing = 18 cycles.
